// File: rtl/agc_mem_arbiter.sv
// Two-port memory arbiter: CTR priority with CPU anti-starvation,
// fixed 3-cycle transactions and fixed-memory write protection.
module agc_mem_arbiter #(
  parameter int AW = 12,
  parameter int DW = 15,
  parameter logic [AW-1:0] FIXED_BASE = 12'h400
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  input  logic          ctr_req,
  input  logic          ctr_we,
  input  logic [AW-1:0] ctr_addr,
  input  logic [DW-1:0] ctr_wdata,
  output logic          ctr_ack,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          gnt_ctr,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t        state;
  logic          last_ctr;
  logic          fault;
  logic          pick_ctr;
  logic          w_we;
  logic          w_prot;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  // CTR wins unless it had the last grant and the CPU is waiting
  always_comb begin
    pick_ctr = ctr_req & ~(last_ctr & cpu_req);
    w_we     = pick_ctr ? ctr_we    : cpu_we;
    w_addr   = pick_ctr ? ctr_addr  : cpu_addr;
    w_wdata  = pick_ctr ? ctr_wdata : cpu_wdata;
    w_prot   = w_we & (w_addr >= FIXED_BASE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_ctr <= 1'b0;
      fault    <= 1'b0;
      cpu_ack  <= 1'b0;
      ctr_ack  <= 1'b0;
      rdata    <= '0;
      err      <= 1'b0;
      gnt_ctr  <= 1'b0;
      busy     <= 1'b0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu_req | ctr_req) begin
            state    <= ACCESS;
            gnt_ctr  <= pick_ctr;
            last_ctr <= pick_ctr;
            mem_addr <= w_addr;
            mem_din  <= w_wdata;
            mem_we   <= w_we & ~w_prot;
            mem_en   <= ~w_prot;
            fault    <= w_prot;
            busy     <= 1'b1;
          end
        end
        ACCESS: begin
          rdata   <= (!mem_we && !fault) ? mem_dout : '0;
          err     <= fault;
          cpu_ack <= ~gnt_ctr;
          ctr_ack <= gnt_ctr;
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          state   <= DONE;
        end
        DONE: begin
          cpu_ack <= 1'b0;
          ctr_ack <= 1'b0;
          err     <= 1'b0;
          fault   <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_agc_mem_arbiter.sv
// Directed bench for agc_mem_arbiter with a behavioural memory
// whose preload values come from a fixed table.
module tb_agc_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, ctr_req, ctr_we;
  logic [11:0] cpu_addr, ctr_addr, mem_addr;
  logic [14:0] cpu_wdata, ctr_wdata, mem_din, mem_dout, rdata;
  logic        cpu_ack, ctr_ack, err, gnt_ctr, busy, mem_en, mem_we;
  logic        wipe;
  logic [14:0] mem [0:4095];
  logic [4095:0] written;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  agc_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .ctr_req(ctr_req), .ctr_we(ctr_we), .ctr_addr(ctr_addr),
    .ctr_wdata(ctr_wdata), .ctr_ack(ctr_ack),
    .rdata(rdata), .err(err), .gnt_ctr(gnt_ctr), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  function automatic logic [14:0] preload(input logic [11:0] a);
    case (a)
      12'h002: preload = 15'h0123;
      12'h003: preload = 15'h0456;
      12'h010: preload = 15'h0789;
      12'h400: preload = 15'h2AAA;
      12'hFFF: preload = 15'h3333;
      default: preload = {3'b000, a};
    endcase
  endfunction

  assign mem_dout = !mem_en ? 15'h0 :
                    written[mem_addr] ? mem[mem_addr] : preload(mem_addr);

  always @(posedge clk) begin
    if (wipe) written <= '0;
    else if (mem_en && mem_we) begin
      mem[mem_addr]     <= mem_din;
      written[mem_addr] <= 1'b1;
    end
  end

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ctr_req = 0; ctr_we = 0; ctr_addr = '0; ctr_wdata = '0;
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %b exp 0", mem_en); end
    checks++; if ({cpu_ack, ctr_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks got %b exp 00", {cpu_ack, ctr_ack}); end
    checks++; if (rdata !== 15'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    checks++; if ({err, gnt_ctr, mem_we} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {err, gnt_ctr, mem_we}); end
    checks++; if ({mem_addr, mem_din} !== 27'h0) begin errors++; $display("FAIL reset_bus got %h exp 0", {mem_addr, mem_din}); end
  endtask

  task automatic test_cpu_read();
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h002;
    @(negedge clk);
    checks++; if ({mem_en, mem_we, busy} !== 3'b101) begin errors++; $display("FAIL rd_access got %b exp 101", {mem_en, mem_we, busy}); end
    checks++; if (mem_addr !== 12'h002) begin errors++; $display("FAIL rd_addr got %h exp 002", mem_addr); end
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_early_ack got %b exp 0", cpu_ack); end
    @(negedge clk);
    checks++; if ({cpu_ack, ctr_ack, err, mem_en} !== 4'b1000) begin errors++; $display("FAIL rd_done got %b exp 1000", {cpu_ack, ctr_ack, err, mem_en}); end
    checks++; if (rdata !== 15'h0123) begin errors++; $display("FAIL rd_data got %h exp 0123", rdata); end
    cpu_req = 0;
    @(negedge clk);
    checks++; if ({cpu_ack, busy} !== 2'b00) begin errors++; $display("FAIL rd_idle got %b exp 00", {cpu_ack, busy}); end
    checks++; if (rdata !== 15'h0123) begin errors++; $display("FAIL rd_hold got %h exp 0123", rdata); end
  endtask

  task automatic test_ctr_write();
    ctr_req = 1; ctr_we = 1; ctr_addr = 12'h025; ctr_wdata = 15'h7FFF;
    @(negedge clk);
    checks++; if ({mem_en, mem_we, gnt_ctr} !== 3'b111) begin errors++; $display("FAIL wr_access got %b exp 111", {mem_en, mem_we, gnt_ctr}); end
    checks++; if (mem_din !== 15'h7FFF) begin errors++; $display("FAIL wr_din got %h exp 7fff", mem_din); end
    @(negedge clk);
    checks++; if ({ctr_ack, cpu_ack, err, mem_we} !== 4'b1000) begin errors++; $display("FAIL wr_done got %b exp 1000", {ctr_ack, cpu_ack, err, mem_we}); end
    checks++; if (rdata !== 15'h0) begin errors++; $display("FAIL wr_rdata got %h exp 0", rdata); end
    ctr_req = 0; ctr_we = 0;
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h025;
    repeat (2) @(negedge clk);
    checks++; if ({cpu_ack, gnt_ctr} !== 2'b10) begin errors++; $display("FAIL wr_rb_ack got %b exp 10", {cpu_ack, gnt_ctr}); end
    checks++; if (rdata !== 15'h7FFF) begin errors++; $display("FAIL wr_readback got %h exp 7fff", rdata); end
    cpu_req = 0;
    @(negedge clk);
  endtask

  task automatic test_fairness();
    logic exp_ctr, exp_cpu;
    rst_n = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h031;
    ctr_req = 1; ctr_we = 0; ctr_addr = 12'h030;
    @(negedge clk);
    rst_n = 1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      exp_ctr = (i == 2) || (i == 8);
      exp_cpu = (i == 5) || (i == 11);
      checks++; if ({ctr_ack, cpu_ack} !== {exp_ctr, exp_cpu}) begin errors++; $display("FAIL fair_acks cyc %0d got %b exp %b", i, {ctr_ack, cpu_ack}, {exp_ctr, exp_cpu}); end
      if (exp_ctr || exp_cpu) begin
        checks++; if (gnt_ctr !== exp_ctr) begin errors++; $display("FAIL fair_gnt cyc %0d got %b exp %b", i, gnt_ctr, exp_ctr); end
        checks++; if (rdata !== (exp_ctr ? 15'h0030 : 15'h0031)) begin errors++; $display("FAIL fair_rdata cyc %0d got %h", i, rdata); end
      end
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_protect();
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h400; cpu_wdata = 15'h1111;
    @(negedge clk);
    checks++; if ({mem_en, mem_we, busy} !== 3'b001) begin errors++; $display("FAIL prot_access got %b exp 001", {mem_en, mem_we, busy}); end
    @(negedge clk);
    checks++; if ({cpu_ack, err} !== 2'b11) begin errors++; $display("FAIL prot_err got %b exp 11", {cpu_ack, err}); end
    checks++; if (rdata !== 15'h0) begin errors++; $display("FAIL prot_rdata got %h exp 0", rdata); end
    cpu_req = 0; cpu_we = 0;
    @(negedge clk);
    cpu_req = 1; cpu_addr = 12'h400;
    repeat (2) @(negedge clk);
    checks++; if ({cpu_ack, err} !== 2'b10) begin errors++; $display("FAIL prot_rd_flags got %b exp 10", {cpu_ack, err}); end
    checks++; if (rdata !== 15'h2AAA) begin errors++; $display("FAIL prot_rd_data got %h exp 2aaa", rdata); end
    cpu_req = 0;
    @(negedge clk);
    ctr_req = 1; ctr_we = 1; ctr_addr = 12'hFFF; ctr_wdata = 15'h0001;
    @(negedge clk);
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL fff_wr_en got %b exp 0", mem_en); end
    @(negedge clk);
    checks++; if ({ctr_ack, err} !== 2'b11) begin errors++; $display("FAIL fff_wr_err got %b exp 11", {ctr_ack, err}); end
    ctr_we = 0;
    repeat (3) @(negedge clk);
    checks++; if ({ctr_ack, err, rdata} !== {2'b10, 15'h3333}) begin errors++; $display("FAIL fff_rd got %b/%h exp 10/3333", {ctr_ack, err}, rdata); end
    ctr_req = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h002;
    @(negedge clk);
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL mid_pre got %b exp 1", mem_en); end
    #2 rst_n = 0;
    #1;
    checks++; if ({mem_en, cpu_ack, busy} !== 3'b000) begin errors++; $display("FAIL mid_abort got %b exp 000", {mem_en, cpu_ack, busy}); end
    @(negedge clk);
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL mid_noack got %b exp 0", cpu_ack); end
    rst_n = 1;
    @(negedge clk);
    checks++; if ({mem_en, mem_addr} !== {1'b1, 12'h002}) begin errors++; $display("FAIL mid_retry got %b/%h exp 1/002", mem_en, mem_addr); end
    @(negedge clk);
    checks++; if ({cpu_ack, rdata} !== {1'b1, 15'h0123}) begin errors++; $display("FAIL mid_done got %b/%h exp 1/0123", cpu_ack, rdata); end
    cpu_req = 0;
    @(negedge clk);
  endtask

  task automatic test_input_change();
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h003;
    @(negedge clk);
    cpu_addr = 12'h010;
    #1;
    checks++; if (mem_addr !== 12'h003) begin errors++; $display("FAIL chg_addr got %h exp 003", mem_addr); end
    @(negedge clk);
    checks++; if ({cpu_ack, rdata} !== {1'b1, 15'h0456}) begin errors++; $display("FAIL chg_data got %b/%h exp 1/0456", cpu_ack, rdata); end
    cpu_req = 0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0;
    wipe = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    test_reset();
    wipe = 0;
    rst_n = 1;
    @(negedge clk);
    test_cpu_read();
    test_ctr_write();
    test_fairness();
    test_protect();
    test_reset_mid();
    test_input_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
